// File: rtl/multi_dev_bridge_if.sv
`default_nettype none
// multi_dev_bridge_if: CPU, data-memory and peripheral-slot signals of the bridge.
// The slave modport is the bridge; the master modport is its environment.
interface multi_dev_bridge_if #(
   parameter int N_DEV = 2
);
   logic                   cpu_req;
   logic [31:0]            cpu_addr;
   logic [3:0]             cpu_byteen;
   logic [31:0]            cpu_wdata;
   logic                   int_req;
   logic                   int_ack;
   logic [31:0]            cpu_rdata;
   logic                   cpu_ready;
   logic                   cpu_err;
   logic [31:0]            mem_addr;
   logic [31:0]            mem_wdata;
   logic [3:0]             dm_byteen;
   logic [31:0]            dm_rdata;
   logic [N_DEV-1:0]       dev_we;
   logic [32*N_DEV-1:0]    dev_rdata;
   logic [N_DEV-1:0]       dev_irq;
   logic [N_DEV-1:0]       irq_clr;
   logic                   int_we;
   logic [5:0]             hwint;

   modport slave (
      input  cpu_req, cpu_addr, cpu_byteen, cpu_wdata, int_req, int_ack,
      input  dm_rdata, dev_rdata, dev_irq, irq_clr,
      output cpu_rdata, cpu_ready, cpu_err, mem_addr, mem_wdata,
      output dm_byteen, dev_we, int_we, hwint
   );

   modport master (
      output cpu_req, cpu_addr, cpu_byteen, cpu_wdata, int_req, int_ack,
      output dm_rdata, dev_rdata, dev_irq, irq_clr,
      input  cpu_rdata, cpu_ready, cpu_err, mem_addr, mem_wdata,
      input  dm_byteen, dev_we, int_we, hwint
   );
endinterface
`default_nettype wire

// File: rtl/multi_dev_bridge.sv
`default_nettype none
// multi_dev_bridge: registered bridge from the CPU memory stage to data memory and
// N_DEV word-addressed slots, with fixed wait states and latched interrupt pending bits.
module multi_dev_bridge #(
   parameter int          N_DEV      = 2,
   parameter logic [31:0] DEV_BASE   = 32'h7f00,
   parameter logic [31:0] DEV_STRIDE = 32'h10,
   parameter int          DEV_SIZE   = 12,
   parameter logic [31:0] DM_LIMIT   = 32'h3000,
   parameter logic [31:0] INT_ADDR   = 32'h7f20,
   parameter int          WAIT_CYC   = 1,
   parameter bit          IRQ_EDGE   = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   multi_dev_bridge_if.slave bus
);

   localparam logic [31:0] c_dev_size  = 32'(DEV_SIZE);
   localparam logic [3:0]  c_wait_init = 4'(WAIT_CYC - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2,
      S_IACK = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [3:0]       be_q, be_d;
   logic             dm_q, dm_d;
   logic [N_DEV-1:0] dev_q, dev_d;
   logic [31:0]      rdata_q, rdata_d;
   logic [N_DEV-1:0] pend_q, pend_d;
   logic [N_DEV-1:0] irq_prev_q;

   logic [31:0]      w_acc_addr;
   logic             w_acc_dm;
   logic [N_DEV-1:0] w_acc_dev;
   logic [31:0]      w_slot_lo [N_DEV];
   logic             w_sel_dm;
   logic [N_DEV-1:0] w_sel_dev;
   logic [31:0]      w_dev_rd;
   logic             w_enter_resp;
   logic             w_resp;
   logic             w_iack;
   logic             w_word;
   logic             w_unmapped;
   logic [N_DEV-1:0] w_clr;
   logic             w_unused;

   assign w_unused   = &{1'b0, bus.cpu_addr[1:0]};
   assign w_acc_addr = {bus.cpu_addr[31:2], 2'b00};
   assign w_acc_dm   = (w_acc_addr < DM_LIMIT);

   generate
      for (genvar gi = 0; gi < N_DEV; gi++) begin : g_slot
         assign w_slot_lo[gi] = DEV_BASE + DEV_STRIDE * 32'(gi);
         assign w_acc_dev[gi] = !w_acc_dm && (w_acc_addr >= w_slot_lo[gi]) &&
                                (w_acc_addr < w_slot_lo[gi] + c_dev_size);
      end
   endgenerate

   // Read data is captured while entering RESP, which may be the accept edge itself.
   always_comb begin
      w_sel_dm  = (state_q == S_IDLE) ? w_acc_dm  : dm_q;
      w_sel_dev = (state_q == S_IDLE) ? w_acc_dev : dev_q;
      w_dev_rd  = '0;
      for (int i = 0; i < N_DEV; i++) begin
         if (w_sel_dev[i]) begin
            w_dev_rd = w_dev_rd | bus.dev_rdata[32*i +: 32];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      be_d         = be_q;
      dm_d         = dm_q;
      dev_d        = dev_q;
      rdata_d      = rdata_q;
      w_enter_resp = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.int_ack) begin
               state_d = S_IACK;
               addr_d  = INT_ADDR;
            end else if (bus.cpu_req && !bus.int_req) begin
               addr_d  = w_acc_addr;
               wdata_d = bus.cpu_wdata;
               be_d    = bus.cpu_byteen;
               dm_d    = w_acc_dm;
               dev_d   = w_acc_dev;
               if (WAIT_CYC == 0) begin
                  state_d      = S_RESP;
                  w_enter_resp = 1'b1;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = c_wait_init;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d      = S_RESP;
               w_enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         S_IACK:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (w_enter_resp) begin
         if (w_sel_dm)        rdata_d = bus.dm_rdata;
         else if (|w_sel_dev) rdata_d = w_dev_rd;
         else                 rdata_d = 32'hbbbb_bbbb;
      end
   end

   assign w_resp     = (state_q == S_RESP);
   assign w_iack     = (state_q == S_IACK);
   assign w_word     = (be_q == 4'hF);
   assign w_unmapped = !dm_q && (dev_q == '0);

   // A completed word write to a slot's offset 0 acknowledges that slot's interrupt.
   always_comb begin
      w_clr = bus.irq_clr;
      for (int i = 0; i < N_DEV; i++) begin
         if (w_resp && w_word && dev_q[i] && (addr_q == w_slot_lo[i])) begin
            w_clr[i] = 1'b1;
         end
      end
      if (IRQ_EDGE) pend_d = (pend_q & ~w_clr) | (bus.dev_irq & ~irq_prev_q);
      else          pend_d = bus.dev_irq;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
         dm_q       <= 1'b0;
         dev_q      <= '0;
         rdata_q    <= '0;
         pend_q     <= '0;
         irq_prev_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         be_q       <= be_d;
         dm_q       <= dm_d;
         dev_q      <= dev_d;
         rdata_q    <= rdata_d;
         pend_q     <= pend_d;
         irq_prev_q <= bus.dev_irq;
      end
   end

   assign bus.cpu_rdata = rdata_q;
   assign bus.cpu_ready = w_resp;
   assign bus.cpu_err   = w_resp && (w_unmapped || ((|dev_q) && (be_q != 4'h0) && !w_word));
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.dm_byteen = w_iack ? 4'hF : ((w_resp && dm_q) ? be_q : 4'h0);
   assign bus.dev_we    = (w_resp && w_word) ? dev_q : '0;
   assign bus.int_we    = w_iack;

   always_comb begin
      bus.hwint              = '0;
      bus.hwint[N_DEV-1:0]   = pend_q;
   end

endmodule
`default_nettype wire
